// File: rtl/key_pio_in_pkg.sv
// key_pio_in_pkg: register map constants and sizing helper for the key input port
package key_pio_in_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_RSVD = 2'd1;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // bits needed to count 0..n-1, never less than one bit
   function automatic int clog2_min1(input int n);
      int r = 1;
      while ((longint'(1) << r) < longint'(n)) r++;
      return r;
   endfunction

endpackage

// File: rtl/key_pio_in_if.sv
// key_pio_in_if: Avalon-MM slave bus plus interrupt line of the key input port
interface key_pio_in_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (output address, chipselect, write_n, writedata, input readdata, irq);
   modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/key_pio_in_debounce.sv
// key_debounce: one key bit through a two-flop synchronizer and a stability-count debouncer
module key_debounce
   import key_pio_in_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 50000,
   parameter logic RESET_LEVEL     = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic deb,
   output logic upd
);
   localparam int              CW   = clog2_min1(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2;
   logic [CW-1:0] cnt;

   // strobe in the cycle whose closing edge commits the new debounced level
   assign upd = (sync2 != deb) && (cnt == LAST);

   // synchronize, then count consecutive disagreeing samples; any agreeing sample restarts the count
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= RESET_LEVEL;
         sync2 <= RESET_LEVEL;
         deb   <= RESET_LEVEL;
         cnt   <= '0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         cnt   <= (sync2 == deb || upd) ? '0 : cnt + 1'b1;
         if (upd) deb <= sync2;
      end
   end
endmodule

// File: rtl/key_pio_in.sv
// key_pio_in: debounced push-button input port with edge capture and maskable interrupt
module key_pio_in
   import key_pio_in_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter bit               CAPTURE_FALLING = 1'b1,
   parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
   input  logic             clk,
   input  logic             reset_n,
   key_pio_in_if.slave      bus,
   input  logic [WIDTH-1:0] in_port
);
   logic [WIDTH-1:0] deb, upd, cap_set, clr, irq_mask, edge_cap;
   logic [31:0]      rd_mux;
   logic             wr;

   for (genvar i = 0; i < WIDTH; i++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(RESET_LEVEL[i])) u_deb (
         .clk(clk), .reset_n(reset_n), .din(in_port[i]), .deb(deb[i]), .upd(upd[i])
      );
   end

   // an update flips deb, so the current level tells which direction the edge goes
   always_comb begin
      wr      = bus.chipselect && !bus.write_n;
      cap_set = upd & (CAPTURE_FALLING ? deb : ~deb);
      clr     = (wr && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;
      rd_mux  = bus.address == ADDR_DATA ? 32'(deb) :
                bus.address == ADDR_MASK ? 32'(irq_mask) :
                bus.address == ADDR_EDGE ? 32'(edge_cap) : 32'd0;
   end

   assign bus.irq = |(edge_cap & irq_mask);

   // register file; a new edge overrides a simultaneous write-1-clear so it is never lost
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_mask     <= '0;
         edge_cap     <= '0;
         bus.readdata <= '0;
      end else begin
         if (wr && bus.address == ADDR_MASK) irq_mask <= bus.writedata[WIDTH-1:0];
         edge_cap     <= (edge_cap & ~clr) | cap_set;
         bus.readdata <= rd_mux;
      end
   end
endmodule

// File: doc/key_pio_in.md
Name: key_pio_in

Overview:
- Avalon-MM slave input port: brings FPGA-side push-button levels into the HPS register space.
- Per-bit pipeline: two-stage synchronizer, then stability-counter debouncer.
- Latches debounced edges into a write-1-to-clear edge-capture register and raises a maskable level interrupt.
- Sits on the lightweight HPS-to-FPGA bridge, beside the existing LED output port.

Parameters:
- WIDTH, 4: number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before the debounced level changes (>=1; 1 ms at 50 MHz).
- CAPTURE_FALLING, 1: 1 captures falling debounced edges (active-low keys), 0 captures rising.
- RESET_LEVEL, all ones: WIDTH-bit reset value of synchronizer and debounced registers; prevents spurious edges after reset.

Ports:
- clk  in  1  single system clock.
- reset_n  in  1  reset; synchronous, active-low.
- address  in  2  word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous key inputs.
- readdata  out  32  read data; registered, zero-extended above WIDTH.
- irq  out  1  level interrupt to HPS.

Behaviour:
- Reset (reset_n low at a clk edge):
  - sync1, sync2 and deb reset to RESET_LEVEL.
  - All debounce counters, edge_cap, irq_mask and readdata reset to 0; irq is 0.
- Register map:
  - 0: data, read-only, deb.
  - 1: reserved, reads 0, writes ignored.
  - 2: irq_mask, RW, bits [WIDTH-1:0].
  - 3: edge_cap, read; writing a 1 clears that bit.
  - Upper bits read 0.
- Write: takes effect at the clk edge where chipselect=1 and write_n=0; no wait states.
- Read: readdata is registered every cycle from the current address (no read strobe), so read latency is 1 cycle. The bus uses fixed read latency 1.
- Synchronizer: sync1 <= in_port; sync2 <= sync1.
- Debounce, per bit:
  - sync2 == deb: cnt <= 0.
  - sync2 != deb and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != deb and cnt == DEBOUNCE_CYCLES-1: deb <= sync2, cnt <= 0, one-cycle strobe upd.
  - Any sample where sync2 == deb restarts the count (bounce rejection).
  - Counter width is clog2(DEBOUNCE_CYCLES), minimum 1.
- Latency: an in_port change set up before edge E appears in deb at edge E+1+DEBOUNCE_CYCLES. It is visible on readdata one further cycle later.
- Edge capture: edge_cap[i] is set on the same edge as upd[i] when the new deb[i] matches the capture polarity. It stays set until cleared.
- Simultaneous set and write-1-clear on the same bit: set wins; no edge is lost.
- Writing 0 bits to edge_cap has no effect.
- irq = |(edge_cap & irq_mask), combinational from registers; it is 0 after reset.
- Changing the mask does not alter edge_cap.
- Reset mid-debounce: the count is discarded and deb returns to RESET_LEVEL. If the key is held at reset release it produces one edge after DEBOUNCE_CYCLES.

Decomposition:
- Shared package/include holds:
  - address constants ADDR_DATA=0, ADDR_RSVD=1, ADDR_MASK=2, ADDR_EDGE=3;
  - the clog2 helper function.
- Sub-module key_debounce: one bit, with sync1/sync2, counter, deb and upd output.
  - Instantiated WIDTH times via generate.
  - Top level holds the register file, edge logic, read mux and irq.

Test Plan:
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=4, CAPTURE_FALLING=1.
1. Reset: hold reset_n=0 for 3 cycles with in_port=4'b0000, then release. Read addr 0 returns 0xF; addr 2 and addr 3 return 0; irq=0. The first 0xF->0x0 deb update occurs 5 edges later.
2. Clean press: in_port 0xF->0xE. deb[0] falls at edge E+5 and edge_cap reads 0x1. With irq_mask=0x1 written beforehand, irq rises on that same edge.
3. Bounce: toggle in_port[1] 1->0->1->0 with 2-cycle dwell, then hold 0. deb[1] changes only 5 edges after the final transition; edge_cap=0x2 (a single set).
4. Clear race: with edge_cap=0x1, write 0x1 to addr 3 on the same edge as a new upd for bit 0 falling. edge_cap stays 0x1. A later write of 0x1 with no edge clears it to 0 and irq drops the same cycle.
5. Mask: edge_cap=0x4, irq_mask=0x0 gives irq=0. Write 0x4 to addr 2: irq=1 the next cycle. Addr 1 reads 0 after writing 0xFFFFFFFF.
6. Release, rising edge only: bit 0 goes 0->1 after debounce. No edge_cap bit is set; data reads 0xF.
